// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole sequencer.
package mole_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      UP,
      GAP,
      OVER
   } state_t;

   localparam int         HOLES     = 4;
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [HOLES-1:0] hole_onehot(input logic [1:0] h);
      return HOLES'(1) << h;
   endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Galois LFSR; advances every clock so player timing perturbs the sequence.
module mole_lfsr
   import mole_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] lfsr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else if (lfsr[0]) begin
         lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
      end else begin
         lfsr <= lfsr >> 1;
      end
   end

endmodule

// File: rtl/mole_sequencer.sv
// Whack-a-mole round/game controller: picks the lit hole, times it, judges key presses.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   SPAWN | one cycle, lights the next mole
//   UP    | mole lit, presses judged
//   GAP   | dark gap, presses ignored
//   OVER  | game finished, results held
module mole_sequencer
   import mole_pkg::*;
#(
   parameter int UP_TICKS  = 50,
   parameter int GAP_TICKS = 10,
   parameter int ROUNDS    = 20,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             start,
   input  logic [3:0]       key_pulse,
   output logic [3:0]       mole_led,
   output logic [CNT_W-1:0] score,
   output logic [CNT_W-1:0] miss,
   output logic             game_over,
   output logic             busy
);

   localparam int TMR_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] UP_LOAD    = TMR_W'(UP_TICKS - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_TICKS - 1);
   localparam logic [7:0]       ROUND_LAST = 8'(ROUNDS);

   state_t           state;
   logic [7:0]       lfsr;
   logic [TMR_W-1:0] tmr;
   logic [7:0]       round;
   logic [1:0]       prev_hole;
   logic [1:0]       cand;
   logic [1:0]       hole;
   logic             hit;
   logic             wrong;
   logic             tmr_zero;
   logic             unused_lfsr;

   mole_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .lfsr  (lfsr)
   );

   assign unused_lfsr = ^lfsr[7:2];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Never light the same hole twice in a row; the 2-bit add wraps 3 -> 0.
   always_comb begin
      cand     = lfsr[1:0];
      hole     = (cand == prev_hole) ? cand + 2'd1 : cand;
      hit      = |(key_pulse & mole_led);
      wrong    = (|key_pulse) & ~hit;
      tmr_zero = (tmr == '0);
   end

   assign game_over = (state == OVER);
   assign busy      = (state == SPAWN) || (state == UP) || (state == GAP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mole_led  <= '0;
         score     <= '0;
         miss      <= '0;
         tmr       <= '0;
         round     <= '0;
         prev_hole <= '0;
      end else begin
         case (state)
            IDLE, OVER: begin
               mole_led <= '0;
               if (start) begin
                  score <= '0;
                  miss  <= '0;
                  round <= '0;
                  state <= SPAWN;
               end
            end
            SPAWN: begin
               mole_led  <= hole_onehot(hole);
               prev_hole <= hole;
               round     <= round + 8'd1;
               tmr       <= UP_LOAD;
               state     <= UP;
            end
            UP: begin
               if (hit) begin
                  score    <= sat_inc(score);
                  mole_led <= '0;
                  tmr      <= GAP_LOAD;
                  state    <= GAP;
               end else if (wrong) begin
                  miss <= sat_inc(miss);
               end else if (tick && tmr_zero) begin
                  miss     <= sat_inc(miss);
                  mole_led <= '0;
                  tmr      <= GAP_LOAD;
                  state    <= GAP;
               end else if (tick) begin
                  tmr <= tmr - 1'b1;
               end
            end
            GAP: begin
               if (tick && tmr_zero) begin
                  state <= (round == ROUND_LAST) ? OVER : SPAWN;
               end else if (tick) begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: begin
               mole_led <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
